// File: rtl/ring_buf_writer.sv
// Ring-buffer write side: gathers client words into a DEPTH-entry buffer,
// then drains each batch (closed by fill or LAST) into a downstream FIFO.
module ring_buf_writer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       WREN,
  input  logic [WIDTH-1:0]           WRDATA,
  input  logic                       LAST,
  output logic                       FULL,
  output logic                       OVF,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic [WIDTH-1:0]           FIFO_WRDATA,
  output logic                       FIFO_WREN,
  input  logic                       FIFO_WRFULL,
  output logic                       FIFO_DONE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     widx_q;
  logic [AW-1:0]     ridx_q;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              last_q;
  logic [WIDTH-1:0]  data_q [DEPTH];

  logic              accept;
  logic              fifo_wr;
  logic [CW-1:0]     count_inc;

  assign accept    = WREN & (state_q == FILL);
  assign count_inc = count_q + CW'(1);
  // Reset gates the strobe so a mid-drain reset never issues a write.
  assign fifo_wr   = RESETn & ~FIFO_WRFULL & (state_q == DRAIN) & (count_q != '0);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= FILL;
      widx_q  <= '0;
      ridx_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (WREN && state_q != FILL) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        FILL: begin
          if (WREN) begin
            widx_q  <= widx_q + AW'(1);
            count_q <= count_inc;
            if (LAST || count_inc == DEPTH_C) begin
              state_q <= DRAIN;
              last_q  <= LAST;
            end
          end
        end
        DRAIN: begin
          if (fifo_wr) begin
            ridx_q  <= ridx_q + AW'(1);
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_q <= last_q ? DONE : FILL;
            end
          end
        end
        DONE: begin
          state_q <= FILL;
          last_q  <= 1'b0;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESETn && accept) begin
      data_q[widx_q] <= WRDATA;
    end
  end

  assign FULL        = (state_q != FILL);
  assign OVF         = ovf_q;
  assign COUNT       = count_q;
  assign FIFO_WRDATA = data_q[ridx_q];
  assign FIFO_WREN   = fifo_wr;
  assign FIFO_DONE   = (state_q == DONE);

endmodule

// File: tb/tb_ring_buf_writer.sv
// Bench for ring_buf_writer (DEPTH=4): queue-based reference model checked
// every cycle, plus literal expectations on the drained word stream.
module tb_ring_buf_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RESETn;
  logic             WREN;
  logic [WIDTH-1:0] WRDATA;
  logic             LAST;
  logic             FULL;
  logic             OVF;
  logic [2:0]       COUNT;
  logic [WIDTH-1:0] FIFO_WRDATA;
  logic             FIFO_WREN;
  logic             FIFO_WRFULL;
  logic             FIFO_DONE;

  ring_buf_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .WREN        (WREN),
    .WRDATA      (WRDATA),
    .LAST        (LAST),
    .FULL        (FULL),
    .OVF         (OVF),
    .COUNT       (COUNT),
    .FIFO_WRDATA (FIFO_WRDATA),
    .FIFO_WREN   (FIFO_WREN),
    .FIFO_WRFULL (FIFO_WRFULL),
    .FIFO_DONE   (FIFO_DONE)
  );

  always #5 CLK = ~CLK;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: pending words as a queue, batch phase as a plain mode.
  typedef enum {M_COLLECT, M_EMPTYING, M_FINISHED} mode_t;
  logic [WIDTH-1:0] m_q[$];
  mode_t            m_mode = M_COLLECT;
  bit               m_ovf  = 0;
  bit               m_lastbatch = 0;
  bit               armed  = 0;

  logic [WIDTH-1:0] obs[$];
  int unsigned      done_cnt = 0;

  always @(posedge CLK) begin
    if (!RESETn) begin
      m_q.delete();
      m_mode = M_COLLECT;
      m_ovf = 0;
      m_lastbatch = 0;
    end else begin
      if (WREN && m_mode != M_COLLECT) m_ovf = 1;
      case (m_mode)
        M_COLLECT: if (WREN) begin
          m_q.push_back(WRDATA);
          if (LAST || m_q.size() == DEPTH) begin
            m_mode = M_EMPTYING;
            m_lastbatch = LAST;
          end
        end
        M_EMPTYING: if (!FIFO_WRFULL && m_q.size() > 0) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = m_lastbatch ? M_FINISHED : M_COLLECT;
        end
        M_FINISHED: begin
          m_mode = M_COLLECT;
          m_lastbatch = 0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      bit exp_wren;
      exp_wren = RESETn && m_mode == M_EMPTYING && !FIFO_WRFULL && m_q.size() > 0;
      chk("FULL", 64'(FULL), 64'(m_mode != M_COLLECT));
      chk("COUNT", 64'(COUNT), 64'(m_q.size()));
      chk("OVF", 64'(OVF), 64'(m_ovf));
      chk("FIFO_DONE", 64'(FIFO_DONE), 64'(m_mode == M_FINISHED));
      chk("FIFO_WREN", 64'(FIFO_WREN), 64'(exp_wren));
      if (exp_wren) chk("FIFO_WRDATA", 64'(FIFO_WRDATA), 64'(m_q[0]));
      if (FIFO_WREN === 1'b1) obs.push_back(FIFO_WRDATA);
      if (FIFO_DONE === 1'b1) done_cnt++;
    end
  end

  // Inputs change 1 time unit after the rising edge; task returns at the same point.
  task automatic drive(input logic wr, input logic [WIDTH-1:0] d, input logic lst, input logic wf);
    WREN = wr; WRDATA = d; LAST = lst; FIFO_WRFULL = wf;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [WIDTH-1:0] exp_s[$];

  task automatic check_stream(input string nm, input int unsigned dones);
    chk({nm, "_len"}, 64'(obs.size()), 64'(exp_s.size()));
    for (int unsigned i = 0; i < exp_s.size() && i < obs.size(); i++)
      chk({nm, "_word"}, 64'(obs[i]), 64'(exp_s[i]));
    chk({nm, "_dones"}, 64'(done_cnt), 64'(dones));
    obs.delete();
    exp_s.delete();
    done_cnt = 0;
  endtask

  initial begin
    RESETn = 1'b0; WREN = 1'b0; WRDATA = '0; LAST = 1'b0; FIFO_WRFULL = 1'b0;
    @(posedge CLK); #1;
    armed = 1;
    chk("reset_COUNT", 64'(COUNT), 64'd0);
    chk("reset_FULL", 64'(FULL), 64'd0);
    chk("reset_OVF", 64'(OVF), 64'd0);
    chk("reset_DONE", 64'(FIFO_DONE), 64'd0);
    @(posedge CLK); #1;
    RESETn = 1'b1;

    // 1: full batch, no LAST
    drive(1, 32'hA, 0, 0); drive(1, 32'hB, 0, 0); drive(1, 32'hC, 0, 0); drive(1, 32'hD, 0, 0);
    chk("t1_full_after_D", 64'(FULL), 64'd1);
    chk("t1_first_wren", 64'(FIFO_WREN), 64'd1);
    idle(6);
    chk("t1_full_end", 64'(FULL), 64'd0);
    chk("t1_count_end", 64'(COUNT), 64'd0);
    exp_s = '{32'hA, 32'hB, 32'hC, 32'hD};
    check_stream("t1", 0);

    // 2: LAST-terminated batch of two
    drive(1, 32'h11, 0, 0); drive(1, 32'h22, 1, 0);
    idle(2);
    chk("t2_done_pulse", 64'(FIFO_DONE), 64'd1);
    idle(1);
    chk("t2_done_gone", 64'(FIFO_DONE), 64'd0);
    chk("t2_full_end", 64'(FULL), 64'd0);
    idle(2);
    exp_s = '{32'h11, 32'h22};
    check_stream("t2", 1);

    // 3: backpressure after the second FIFO write
    drive(1, 32'h31, 0, 0); drive(1, 32'h32, 0, 0); drive(1, 32'h33, 0, 0); drive(1, 32'h34, 0, 0);
    idle(2);
    drive(0, '0, 0, 1); drive(0, '0, 0, 1);
    chk("t3_stall_count", 64'(COUNT), 64'd2);
    chk("t3_stall_wren", 64'(FIFO_WREN), 64'd0);
    drive(0, '0, 0, 1);
    idle(5);
    exp_s = '{32'h31, 32'h32, 32'h33, 32'h34};
    check_stream("t3", 0);

    // 4: overflow write is dropped, OVF sticks across batches
    drive(1, 32'h41, 0, 0); drive(1, 32'h42, 0, 0); drive(1, 32'h43, 0, 0); drive(1, 32'h44, 0, 0);
    drive(1, 32'hEE, 0, 0);
    chk("t4_ovf_set", 64'(OVF), 64'd1);
    idle(5);
    drive(1, 32'h51, 0, 0); drive(1, 32'h52, 1, 0);
    idle(5);
    chk("t4_ovf_sticky", 64'(OVF), 64'd1);
    exp_s = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h51, 32'h52};
    check_stream("t4", 1);

    // 5: reset mid-drain
    drive(1, 32'h61, 0, 0); drive(1, 32'h62, 0, 0); drive(1, 32'h63, 0, 0); drive(1, 32'h64, 0, 0);
    idle(2);
    RESETn = 1'b0;
    #4 chk("t5_reset_wren", 64'(FIFO_WREN), 64'd0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    chk("t5_count", 64'(COUNT), 64'd0);
    chk("t5_full", 64'(FULL), 64'd0);
    chk("t5_ovf", 64'(OVF), 64'd0);
    chk("t5_done", 64'(FIFO_DONE), 64'd0);
    drive(1, 32'h1, 0, 0); drive(1, 32'h2, 1, 0);
    idle(5);
    exp_s = '{32'h61, 32'h62, 32'h1, 32'h2};
    check_stream("t5", 1);

    // 6: three LAST batches of three, pointers wrap
    for (int unsigned b = 0; b < 3; b++) begin
      for (int unsigned k = 0; k < 3; k++)
        drive(1, WIDTH'(b * 3 + k + 1), (k == 2), 0);
      idle(5);
    end
    exp_s = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9};
    check_stream("t6", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
